csr_access_ctrl: RTL and testbench

Sequencer between the execute stage and the CSR register file. It accepts one Zicsr instruction at a time and performs the read-modify-write (CSRRW/RS/RC and immediate forms). It drives the CSR file's address, write data and single-cycle write strobe, waits for the file's `write_done`, and returns the old CSR value for rd. It stalls the pipeline while busy and flags illegal CSR accesses.

---
 rtl/csr_access_ctrl.sv | 130 +++++++++++++
 tb/tb_csr_access_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: Zicsr read-modify-write sequencer between execute and the CSR file.
// Define CSR_READONLY_TRAP_EN to trap writes to read-only CSRs (addr[11:10]==2'b11).
module csr_access_ctrl #(
  parameter int DONE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func3,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rd_idx,
  input  logic [11:0] req_csr_addr,
  input  logic        flush,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_we,
  input  logic [31:0] csr_rdata,
  input  logic        csr_write_done,
  output logic        resp_valid,
  output logic [4:0]  resp_rd_idx,
  output logic        resp_rd_we,
  output logic [31:0] resp_rd_data,
  output logic        resp_illegal,
  output logic        resp_err,
  output logic        busy
);
  localparam int CW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT, RESP} state_t;
  state_t        state;
  logic [2:0]    func3;
  logic [4:0]    rs1_idx, rd_idx;
  logic [31:0]   rs1_data, old_q, src, new_val;
  logic [CW-1:0] cnt;
  logic          illegal, do_write, trap;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE || req_valid;
  always_comb begin
    src = func3[2] ? {27'd0, rs1_idx} : rs1_data;
    new_val = func3[1:0] == 2'b01 ? src : func3[1:0] == 2'b10 ? csr_rdata | src : csr_rdata & ~src;
    illegal = func3[1:0] == 2'b00;
    do_write = func3[1:0] == 2'b01 || rs1_idx != 5'd0;
`ifdef CSR_READONLY_TRAP_EN
    trap = illegal || (do_write && csr_addr[11:10] == 2'b11);
`else
    trap = illegal;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      func3 <= '0;
      rs1_idx <= '0;
      rs1_data <= '0;
      rd_idx <= '0;
      old_q <= '0;
      cnt <= '0;
      csr_addr <= '0;
      csr_wdata <= '0;
      csr_we <= 1'b0;
      resp_valid <= 1'b0;
      resp_rd_idx <= '0;
      resp_rd_we <= 1'b0;
      resp_rd_data <= '0;
      resp_illegal <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= READ;
          func3 <= req_func3;
          rs1_idx <= req_rs1_idx;
          rs1_data <= req_rs1_data;
          rd_idx <= req_rd_idx;
          csr_addr <= req_csr_addr;
        end
        READ: if (flush) begin
          state <= IDLE;
          csr_addr <= '0;
        end else if (trap) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_illegal <= 1'b1;
          resp_rd_idx <= rd_idx;
          resp_rd_data <= csr_rdata;
        end else if (do_write) begin
          state <= WRITE;
          csr_we <= 1'b1;
          csr_wdata <= new_val;
          old_q <= csr_rdata;
        end else begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_rd_we <= rd_idx != 5'd0;
          resp_rd_idx <= rd_idx;
          resp_rd_data <= csr_rdata;
        end
        WRITE: begin
          state <= WAIT;
          csr_we <= 1'b0;
          cnt <= '0;
        end
        // the ack is honoured even in the last allowed WAIT cycle
        WAIT: if (csr_write_done || cnt == CW'(DONE_TIMEOUT - 1)) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_err <= !csr_write_done;
          resp_rd_we <= csr_write_done && rd_idx != 5'd0;
          resp_rd_idx <= rd_idx;
          resp_rd_data <= old_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          state <= IDLE;
          csr_addr <= '0;
          csr_wdata <= '0;
          resp_valid <= 1'b0;
          resp_rd_idx <= '0;
          resp_rd_we <= 1'b0;
          resp_rd_data <= '0;
          resp_illegal <= 1'b0;
          resp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: table-driven scoreboard bench for csr_access_ctrl with a behavioural CSR file.
module tb_csr_access_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, flush = 1'b0;
  logic        req_ready, csr_we, csr_write_done, resp_valid, resp_rd_we, resp_illegal, resp_err, busy;
  logic [2:0]  req_func3 = '0;
  logic [4:0]  req_rs1_idx = '0, req_rd_idx = '0, resp_rd_idx;
  logic [31:0] req_rs1_data = '0, csr_wdata, csr_rdata, resp_rd_data;
  logic [11:0] req_csr_addr = '0, csr_addr;
  logic [31:0] mem [4096];
  logic        ack_en = 1'b1, pl_en = 1'b0, prev_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          cyc = 0, checks = 0, errors = 0;

  typedef struct {
    logic [2:0] f3; logic [4:0] rs1; logic [31:0] d; logic [4:0] rd; logic [11:0] a;
    logic [31:0] init; logic wr; logic [31:0] wd; logic rdwe; logic ill;
  } vec_t;
  typedef struct {int cyc; logic [31:0] wd;} stb_t;
  typedef struct {int cyc; logic [4:0] rd; logic we; logic [31:0] data; logic ill; logic err; logic chk;} rsp_t;
  stb_t we_q[$];
  rsp_t rs_q[$];
  stb_t mon_s;
  rsp_t mon_r;
  vec_t tbl[11];

  csr_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func3(req_func3), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_rd_idx(req_rd_idx), .req_csr_addr(req_csr_addr), .flush(flush),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
    .csr_write_done(csr_write_done), .resp_valid(resp_valid), .resp_rd_idx(resp_rd_idx),
    .resp_rd_we(resp_rd_we), .resp_rd_data(resp_rd_data), .resp_illegal(resp_illegal),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: combinational read, registered ack, read-only space ignores writes
  assign csr_rdata = mem[csr_addr];
  always @(posedge clk) begin
    csr_write_done <= ack_en && csr_we;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (csr_we && csr_addr[11:10] != 2'b11) mem[csr_addr] <= csr_wdata;
  end

  always @(negedge clk) begin
    if (csr_we) begin
      checks++;
      if (we_q.size() == 0 || prev_we) begin
        errors++;
        $display("FAIL strobe: unexpected csr_we at cyc %0d wdata=%h consecutive=%b", cyc, csr_wdata, prev_we);
      end else begin
        mon_s = we_q.pop_front();
        if (mon_s.cyc != cyc || mon_s.wd != csr_wdata) begin
          errors++;
          $display("FAIL strobe: got cyc=%0d wdata=%h, want cyc=%0d wdata=%h", cyc, csr_wdata, mon_s.cyc, mon_s.wd);
        end
      end
    end
    prev_we = csr_we;
    if (resp_valid) begin
      checks++;
      if (rs_q.size() == 0) begin
        errors++;
        $display("FAIL resp: unexpected resp_valid at cyc %0d", cyc);
      end else begin
        mon_r = rs_q.pop_front();
        if (mon_r.cyc != cyc || resp_rd_idx != mon_r.rd || resp_rd_we != mon_r.we || resp_illegal != mon_r.ill ||
            resp_err != mon_r.err || (mon_r.chk && resp_rd_data != mon_r.data) || req_ready) begin
          errors++;
          $display("FAIL resp: got cyc=%0d rd=%0d we=%b data=%h ill=%b err=%b ready=%b, want cyc=%0d rd=%0d we=%b data=%h ill=%b err=%b ready=0",
                   cyc, resp_rd_idx, resp_rd_we, resp_rd_data, resp_illegal, resp_err, req_ready,
                   mon_r.cyc, mon_r.rd, mon_r.we, mon_r.data, mon_r.ill, mon_r.err);
        end
      end
    end
  end

  task automatic check_idle(input string nm);
    checks++;
    if ({csr_we, resp_valid, resp_rd_we, resp_illegal, resp_err, busy, !req_ready} != 7'd0 ||
        csr_addr != 12'd0 || csr_wdata != 32'd0 || resp_rd_data != 32'd0 || resp_rd_idx != 5'd0) begin
      errors++;
      $display("FAIL %s: got we=%b rv=%b rdwe=%b ill=%b err=%b busy=%b ready=%b addr=%h wdata=%h rdata=%h rd=%0d, want ready=1 and all else 0",
               nm, csr_we, resp_valid, resp_rd_we, resp_illegal, resp_err, busy, req_ready, csr_addr, csr_wdata, resp_rd_data, resp_rd_idx);
    end
  endtask

  // drives at a negedge, returns at the negedge of the READ cycle
  task automatic issue(input vec_t v, input bit pw, input bit pr, input int lat, input bit err);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    pl_en = 1'b1; pl_addr = v.a; pl_data = v.init;
    req_valid = 1'b1; req_func3 = v.f3; req_rs1_idx = v.rs1; req_rs1_data = v.d;
    req_rd_idx = v.rd; req_csr_addr = v.a;
    #1;
    checks++;
    if (!busy || !req_ready) begin
      errors++;
      $display("FAIL accept: got busy=%b ready=%b, want busy=1 ready=1", busy, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; pl_en = 1'b0;
    if (pw) we_q.push_back('{cyc: cyc + 1, wd: v.wd});
    if (pr) rs_q.push_back('{cyc: cyc + lat, rd: v.rd, we: v.rdwe, data: v.init, ill: v.ill, err: err, chk: !v.ill && !err});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((we_q.size() != 0 || rs_q.size() != 0) && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (we_q.size() != 0 || rs_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d strobes and %0d responses never arrived, want 0 and 0", nm, we_q.size(), rs_q.size());
      we_q.delete();
      rs_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_mem(input string nm, input logic [11:0] a, input logic [31:0] exp);
    checks++;
    if (mem[a] != exp) begin
      errors++;
      $display("FAIL %s: csr[%h] got %h, want %h", nm, a, mem[a], exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] exp_mem, input string nm);
    issue(v, v.wr, 1'b1, v.wr ? 3 : 1, 1'b0);
    drain(nm);
    check_mem(nm, v.a, exp_mem);
  endtask

  initial begin
    vec_t v;
    //          f3      rs1    data           rd     addr     init           wr    wdata          rdwe  ill
    tbl[0]  = '{3'b001, 5'd1,  32'hDEADBEEF, 5'd5,  12'h340, 32'h00000011, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[1]  = '{3'b010, 5'd0,  32'hFFFFFFFF, 5'd7,  12'h300, 32'h00001800, 1'b0, 32'h0,        1'b1, 1'b0};
    tbl[2]  = '{3'b111, 5'd4,  32'h0,        5'd3,  12'h304, 32'h0000000F, 1'b1, 32'h0000000B, 1'b1, 1'b0};
    tbl[3]  = '{3'b100, 5'd1,  32'h12345678, 5'd4,  12'h341, 32'h00000055, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[4]  = '{3'b000, 5'd2,  32'h0000FFFF, 5'd6,  12'h342, 32'h00000066, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[5]  = '{3'b010, 5'd2,  32'h000000F0, 5'd0,  12'h341, 32'h0000000F, 1'b1, 32'h000000FF, 1'b0, 1'b0};
    tbl[6]  = '{3'b011, 5'd6,  32'h0000FF00, 5'd9,  12'h342, 32'h0000FFFF, 1'b1, 32'h000000FF, 1'b1, 1'b0};
    tbl[7]  = '{3'b101, 5'h1F, 32'hFFFFFFFF, 5'd1,  12'h343, 32'h00001234, 1'b1, 32'h0000001F, 1'b1, 1'b0};
    tbl[8]  = '{3'b101, 5'd0,  32'hFFFFFFFF, 5'd2,  12'h344, 32'h0000AAAA, 1'b1, 32'h0,        1'b1, 1'b0};
    tbl[9]  = '{3'b110, 5'd0,  32'hFFFFFFFF, 5'd10, 12'h345, 32'h00000077, 1'b0, 32'h0,        1'b1, 1'b0};
    tbl[10] = '{3'b011, 5'd0,  32'h0000FFFF, 5'd11, 12'h346, 32'h00000005, 1'b0, 32'h0,        1'b1, 1'b0};
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    for (int i = 0; i < 11; i++) run_vec(tbl[i], tbl[i].wr ? tbl[i].wd : tbl[i].init, $sformatf("vec%0d", i));
`ifdef CSR_READONLY_TRAP_EN
    run_vec('{3'b001, 5'd1, 32'h99, 5'd8, 12'hC00, 32'h42, 1'b0, 32'h0, 1'b0, 1'b1}, 32'h42, "readonly");
`else
    run_vec('{3'b001, 5'd1, 32'h99, 5'd8, 12'hC00, 32'h42, 1'b1, 32'h99, 1'b1, 1'b0}, 32'h42, "readonly");
`endif
    // ack never comes: 15 WAIT cycles after READ+WRITE
    ack_en = 1'b0;
    v = '{3'b001, 5'd1, 32'h1, 5'd5, 12'h340, 32'h77, 1'b1, 32'h1, 1'b0, 1'b0};
    issue(v, 1'b1, 1'b1, 17, 1'b1);
    drain("timeout");
    check_idle("timeout_idle");
    ack_en = 1'b1;
    v = '{3'b001, 5'd1, 32'h5, 5'd5, 12'h347, 32'h3C, 1'b1, 32'h5, 1'b1, 1'b0};
    issue(v, 1'b0, 1'b0, 0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("flush_read");
    check_mem("flush_read", 12'h347, 32'h3C);
    v = '{3'b001, 5'd1, 32'hA5A5, 5'd12, 12'h348, 32'h21, 1'b1, 32'hA5A5, 1'b1, 1'b0};
    issue(v, 1'b1, 1'b1, 3, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    drain("flush_write");
    check_mem("flush_write", 12'h348, 32'hA5A5);
    ack_en = 1'b0;
    v = '{3'b001, 5'd1, 32'hBEEF, 5'd13, 12'h349, 32'h31, 1'b1, 32'hBEEF, 1'b1, 1'b0};
    issue(v, 1'b1, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset_wait");
    rst_n = 1'b1;
    ack_en = 1'b1;
    run_vec('{3'b010, 5'd0, 32'h0, 5'd14, 12'h34A, 32'h600D, 1'b0, 32'h0, 1'b1, 1'b0}, 32'h600D, "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end
endmodule
